sig_delay_mc: RTL



---
 rtl/sig_delay_pkg.sv | 20 ++
 rtl/sig_delay_ram.sv | 30 +++
 rtl/sig_delay_mc.sv | 111 +++++++++++
 3 files changed

// File: rtl/sig_delay_pkg.sv
// Shared helpers for the multi-channel sample delay line: depth, lane packing
// offsets and the delay clamp also used by the RX-path aligner.
package sig_delay_pkg;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

  // A delay of 0 would alias the read onto the write address, so 1 is the floor.
  function automatic int unsigned clamp_delay(input int unsigned d, input int unsigned max_d);
    if (d == 0) return 1;
    if (d > max_d) return max_d;
    return d;
  endfunction

endpackage

// File: rtl/sig_delay_ram.sv
// Simple dual-port inferred RAM for one lane: write port plus registered read.
// Storage is never reset; the top level mutes lanes until history is valid.
module sig_delay_ram
  import sig_delay_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int ADDR_W = 15
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sig_delay_mc.sv
// Multi-channel runtime-configurable delay line: per-lane clamped delays, fill-based
// muting and a fixed two-cycle pipeline (RAM read, then output register).
module sig_delay_mc
  import sig_delay_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  input  logic [CHANNELS*ADDR_W-1:0]   delay,
  input  logic                         delay_load,
  output logic                         out_valid,
  output logic [CHANNELS*WIDTH-1:0]    out_data,
  output logic [CHANNELS-1:0]          out_primed
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] MAX_D = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]         fill_q, fill_d;
  logic [ADDR_W-1:0]         act_dly_q [CHANNELS];
  logic [ADDR_W-1:0]         act_dly_d [CHANNELS];
  logic [ADDR_W-1:0]         ld_dly [CHANNELS];
  logic [ADDR_W-1:0]         eff_dly [CHANNELS];
  logic [ADDR_W-1:0]         rd_addr [CHANNELS];
  logic [WIDTH-1:0]          rdata [CHANNELS];
  logic [CHANNELS-1:0]       prime;
  logic [CHANNELS-1:0]       prime1_q, prime1_d;
  logic                      v1_q;
  logic                      out_valid_q;
  logic [CHANNELS*WIDTH-1:0] out_data_q, out_data_d;
  logic [CHANNELS-1:0]       out_primed_q, out_primed_d;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    localparam int unsigned LSB_D = lane_lsb(c, ADDR_W);
    localparam int unsigned LSB_X = lane_lsb(c, WIDTH);

    assign ld_dly[c]  = ADDR_W'(clamp_delay(32'(delay[LSB_D +: ADDR_W]), DEPTH - 1));
    // A load coinciding with in_valid already governs that sample.
    assign eff_dly[c] = delay_load ? ld_dly[c] : act_dly_q[c];
    assign rd_addr[c] = wr_ptr_q - eff_dly[c];
    assign prime[c]   = (fill_q >= eff_dly[c]);

    sig_delay_ram #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk_i   (clk),
      .we_i    (in_valid),
      .waddr_i (wr_ptr_q),
      .wdata_i (in_data[LSB_X +: WIDTH]),
      .re_i    (in_valid),
      .raddr_i (rd_addr[c]),
      .rdata_o (rdata[c])
    );
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    act_dly_d    = act_dly_q;
    prime1_d     = prime1_q;
    out_data_d   = out_data_q;
    out_primed_d = out_primed_q;
    if (delay_load) act_dly_d = ld_dly;
    if (in_valid) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (fill_q != MAX_D) fill_d = fill_q + 1'b1;
      prime1_d = prime;
    end
    // Outputs only move on a valid beat, so they hold between pulses.
    if (v1_q) begin
      for (int c = 0; c < CHANNELS; c++) begin
        out_data_d[lane_lsb(c, WIDTH) +: WIDTH] = prime1_q[c] ? rdata[c] : '0;
      end
      out_primed_d = prime1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      prime1_q     <= '0;
      v1_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_primed_q <= '0;
      for (int c = 0; c < CHANNELS; c++) act_dly_q[c] <= ADDR_W'(1);
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      act_dly_q    <= act_dly_d;
      prime1_q     <= prime1_d;
      v1_q         <= in_valid;
      out_valid_q  <= v1_q;
      out_data_q   <= out_data_d;
      out_primed_q <= out_primed_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_primed = out_primed_q;

endmodule
